// File: rtl/transfer_pkg.sv
// Shared types and default parameters for the transfer sequencer.
package transfer_pkg;

    localparam int unsigned LEN_W_DEF       = 8;
    localparam int unsigned INIT_CYCLES_DEF = 4;
    localparam int unsigned ENABLE_DLY_DEF  = 3;
    localparam int unsigned TIMEOUT_DEF     = 16;

    typedef enum logic [2:0] {
        INIT,
        WARM,
        IDLE,
        RUN,
        DONE
    } state_t;

    // Encoding matches the status output
    typedef enum logic [1:0] {
        C_NONE = 2'd0,
        C_END  = 2'd1,
        C_STOP = 2'd2,
        C_ERR  = 2'd3
    } cause_t;

endpackage

// File: rtl/transfer_ctrl_if.sv
// Command / control bundle between the transfer sequencer and its user.
interface transfer_ctrl_if
    import transfer_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEF
);
    logic             req;
    logic [LEN_W-1:0] len;
    logic             irq_en;
    logic             abort;
    logic             beat_ok;
    logic             ack;
    logic             rt;
    logic             enable;
    logic             start;
    logic             rdy;
    logic             endd;
    logic             stop;
    logic             er;
    logic             interrupt;
    logic             status_valid;
    logic [1:0]       status;
    logic [LEN_W-1:0] beats_left;

    modport master (
        output req, len, irq_en, abort, beat_ok,
        input  ack, rt, enable, start, rdy, endd, stop, er, interrupt,
               status_valid, status, beats_left
    );

    modport slave (
        input  req, len, irq_en, abort, beat_ok,
        output ack, rt, enable, start, rdy, endd, stop, er, interrupt,
               status_valid, status, beats_left
    );
endinterface

// File: rtl/beat_timer.sv
// Idle watchdog for RUN: expired is asserted on the TIMEOUT-th consecutive tick.
module beat_timer
    import transfer_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating idle-cycle count, cleared by clr
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (tick && (cnt_q != CNT_W'(TIMEOUT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = tick && !clr && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/transfer_ctrl.sv
// Transfer sequencer: init window, warm-up, one command at a time, one completion cause per transfer.
module transfer_ctrl
    import transfer_pkg::*;
#(
    parameter int unsigned LEN_W       = LEN_W_DEF,
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned ENABLE_DLY  = ENABLE_DLY_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    transfer_ctrl_if.slave  bus
);
    localparam int unsigned PH_MAX = (INIT_CYCLES > ENABLE_DLY) ? INIT_CYCLES : ENABLE_DLY;
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    state_t           state_q, state_d;
    cause_t           cause_c;
    logic             accept_c;
    logic             expired;
    logic             timer_clr_c;
    logic             timer_tick_c;

    logic [PH_W-1:0]  phase_q, phase_d;
    logic [LEN_W-1:0] beats_left_q, beats_left_d;
    logic             irq_en_q, irq_en_d;
    cause_t           cause_q, cause_d;
    cause_t           status_q, status_d;
    logic             status_valid_q, status_valid_d;
    logic             ack_q, ack_d;
    logic             start_q, start_d;
    logic             rdy_q, rdy_d;
    logic             endd_q, endd_d;
    logic             stop_q, stop_d;
    logic             er_q, er_d;
    logic             interrupt_q, interrupt_d;
    logic             rt_q, rt_d;
    logic             enable_q, enable_d;

    assign timer_clr_c  = (state_q != RUN) || bus.beat_ok;
    assign timer_tick_c = (state_q == RUN) && !bus.beat_ok;

    beat_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_beat_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr_c),
        .tick    (timer_tick_c),
        .expired (expired)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and completion cause; a zero-length command fails on the edge after its start
    always_comb begin
        state_d  = state_q;
        cause_c  = C_NONE;
        accept_c = 1'b0;
        case (state_q)
            INIT: begin
                if (phase_q == PH_W'(INIT_CYCLES)) state_d = WARM;
            end
            WARM: begin
                if (phase_q == PH_W'(ENABLE_DLY - 1)) state_d = IDLE;
            end
            IDLE: begin
                if (bus.req && enable_q) begin
                    accept_c = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = DONE;
                    cause_c = C_STOP;
                end else if (bus.beat_ok && (beats_left_q == LEN_W'(1))) begin
                    state_d = DONE;
                    cause_c = C_END;
                end else if ((beats_left_q == '0) || expired) begin
                    state_d = DONE;
                    cause_c = C_ERR;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Registered outputs, beat counter and status derived from the transition
    always_comb begin
        phase_d        = phase_q;
        beats_left_d   = beats_left_q;
        irq_en_d       = irq_en_q;
        cause_d        = cause_q;
        status_d       = status_q;
        status_valid_d = status_valid_q;
        ack_d          = 1'b0;
        start_d        = 1'b0;
        rdy_d          = 1'b0;
        endd_d         = 1'b0;
        stop_d         = 1'b0;
        er_d           = 1'b0;
        interrupt_d    = 1'b0;
        rt_d           = (state_d == INIT);
        enable_d       = enable_q || (state_d == IDLE);

        if (state_d != state_q) begin
            phase_d = '0;
        end else if (phase_q != PH_W'(PH_MAX)) begin
            phase_d = phase_q + PH_W'(1);
        end

        if (accept_c) begin
            ack_d          = 1'b1;
            start_d        = 1'b1;
            beats_left_d   = bus.len;
            irq_en_d       = bus.irq_en;
            status_d       = C_NONE;
            status_valid_d = 1'b0;
        end

        if ((state_q == RUN) && bus.beat_ok && (beats_left_q != '0)) begin
            beats_left_d = beats_left_q - LEN_W'(1);
        end

        if (state_d == DONE) begin
            rdy_d       = 1'b1;
            endd_d      = (cause_c == C_END);
            stop_d      = (cause_c == C_STOP);
            er_d        = (cause_c == C_ERR);
            interrupt_d = irq_en_q;
            cause_d     = cause_c;
        end

        if (state_q == DONE) begin
            status_d       = cause_q;
            status_valid_d = 1'b1;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q        <= '0;
            beats_left_q   <= '0;
            irq_en_q       <= 1'b0;
            cause_q        <= C_NONE;
            status_q       <= C_NONE;
            status_valid_q <= 1'b0;
            ack_q          <= 1'b0;
            start_q        <= 1'b0;
            rdy_q          <= 1'b0;
            endd_q         <= 1'b0;
            stop_q         <= 1'b0;
            er_q           <= 1'b0;
            interrupt_q    <= 1'b0;
            rt_q           <= 1'b1;
            enable_q       <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            beats_left_q   <= beats_left_d;
            irq_en_q       <= irq_en_d;
            cause_q        <= cause_d;
            status_q       <= status_d;
            status_valid_q <= status_valid_d;
            ack_q          <= ack_d;
            start_q        <= start_d;
            rdy_q          <= rdy_d;
            endd_q         <= endd_d;
            stop_q         <= stop_d;
            er_q           <= er_d;
            interrupt_q    <= interrupt_d;
            rt_q           <= rt_d;
            enable_q       <= enable_d;
        end
    end

    assign bus.ack          = ack_q;
    assign bus.start        = start_q;
    assign bus.rdy          = rdy_q;
    assign bus.endd         = endd_q;
    assign bus.stop         = stop_q;
    assign bus.er           = er_q;
    assign bus.interrupt    = interrupt_q;
    assign bus.status_valid = status_valid_q;
    assign bus.status       = status_q;
    assign bus.beats_left   = beats_left_q;
    assign bus.rt           = rt_q;
    assign bus.enable       = enable_q;

endmodule

// File: tb/tb_transfer_ctrl.sv
// Directed bench for transfer_ctrl: per-cycle vector table plus init, timeout, back-to-back and reset sequences.
module tb_transfer_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    transfer_ctrl_if #(.LEN_W(8)) bus ();

    transfer_ctrl #(
        .LEN_W       (8),
        .INIT_CYCLES (4),
        .ENABLE_DLY  (3),
        .TIMEOUT     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {rt, enable, ack, start, rdy, endd, stop, er, interrupt, status_valid, status, beats_left}
    logic [19:0] act_w;
    assign act_w = {bus.rt, bus.enable, bus.ack, bus.start, bus.rdy, bus.endd, bus.stop,
                    bus.er, bus.interrupt, bus.status_valid, bus.status, bus.beats_left};

    typedef struct {
        logic       req;
        logic [7:0] len;
        logic       irq_en;
        logic       abort;
        logic       beat_ok;
        logic       ack;
        logic       start;
        logic       rdy;
        logic       endd;
        logic       stop;
        logic       er;
        logic       intr;
        logic       sv;
        logic [1:0] st;
        logic [7:0] bl;
    } vec_t;

    vec_t tbl [21];

    function automatic logic [19:0] ex(input logic rt, input logic en, input logic ack,
                                       input logic st, input logic rdy, input logic endd,
                                       input logic stop, input logic er, input logic intr,
                                       input logic sv, input logic [1:0] s, input logic [7:0] bl);
        return {rt, en, ack, st, rdy, endd, stop, er, intr, sv, s, bl};
    endfunction

    function automatic vec_t mkv(input logic req, input logic [7:0] len, input logic irq,
                                 input logic abort, input logic beat,
                                 input logic ack, input logic start, input logic rdy,
                                 input logic endd, input logic stop, input logic er,
                                 input logic intr, input logic sv, input logic [1:0] st,
                                 input logic [7:0] bl);
        vec_t v;
        v.req = req; v.len = len; v.irq_en = irq; v.abort = abort; v.beat_ok = beat;
        v.ack = ack; v.start = start; v.rdy = rdy; v.endd = endd; v.stop = stop;
        v.er = er; v.intr = intr; v.sv = sv; v.st = st; v.bl = bl;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic req, input logic [7:0] len, input logic irq,
                         input logic abort, input logic beat);
        bus.req = req; bus.len = len; bus.irq_en = irq; bus.abort = abort; bus.beat_ok = beat;
    endtask

    task automatic check(input string name, input logic [19:0] exp);
        checks++;
        if (act_w !== exp) begin
            failures++;
            $display("FAIL %s: got rt,en,ack,start,rdy,endd,stop,er,int,sv,status,bl=%b_%h expected %b_%h",
                     name, act_w[19:10], act_w[9:0], exp[19:10], exp[9:0]);
        end
    endtask

    // rt high for 4 cycles after release, enable rises 3 cycles after rt falls
    task automatic init_seq(input string tag);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("%s_init%0d", tag, k),
                  ex(k <= 4, k >= 8, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        drive(0, 8'd0, 0, 0, 0);

        // Table: starts in IDLE right after the init sequence
        tbl[0]  = mkv(1, 8'd3, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd3);
        tbl[1]  = mkv(0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd2);
        tbl[2]  = mkv(0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd1);
        tbl[3]  = mkv(0, 8'd0, 0, 0, 1,  0, 0, 1, 1, 0, 0, 1, 0, 2'd0, 8'd0);
        tbl[4]  = mkv(0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 8'd0);
        tbl[5]  = mkv(1, 8'd5, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd5);
        tbl[6]  = mkv(0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd4);
        tbl[7]  = mkv(0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd3);
        tbl[8]  = mkv(0, 8'd0, 0, 1, 0,  0, 0, 1, 0, 1, 0, 0, 0, 2'd0, 8'd3);
        tbl[9]  = mkv(0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 8'd3);
        tbl[10] = mkv(1, 8'd2, 1, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd2);
        tbl[11] = mkv(0, 8'd0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd1);
        tbl[12] = mkv(0, 8'd0, 0, 1, 1,  0, 0, 1, 0, 1, 0, 1, 0, 2'd0, 8'd0);
        tbl[13] = mkv(0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd2, 8'd0);
        tbl[14] = mkv(1, 8'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        tbl[15] = mkv(1, 8'd0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 8'd0);
        tbl[16] = mkv(1, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd0);
        tbl[17] = mkv(1, 8'd0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0);
        tbl[18] = mkv(0, 8'd0, 0, 0, 0,  0, 0, 1, 0, 0, 1, 0, 0, 2'd0, 8'd0);
        tbl[19] = mkv(0, 8'd0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd0);
        tbl[20] = mkv(0, 8'd0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd0);

        // Reset: async assert, then release between edges
        rst = 1'b1;
        #1 rst = 1'b0;
        #2;
        check("reset_state", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        init_seq("t1");

        // Directed per-cycle vectors: END, STOP, STOP over final beat, zero length, req in DONE
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].req, tbl[i].len, tbl[i].irq_en, tbl[i].abort, tbl[i].beat_ok);
            step();
            check($sformatf("vec%0d", i),
                  ex(0, 1, tbl[i].ack, tbl[i].start, tbl[i].rdy, tbl[i].endd, tbl[i].stop,
                     tbl[i].er, tbl[i].intr, tbl[i].sv, tbl[i].st, tbl[i].bl));
        end

        // Timeout: len=4, no beats, er exactly 16 cycles after start
        drive(1, 8'd4, 1, 0, 0);
        step();
        check("to_start", ex(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd4));
        drive(0, 8'd0, 0, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 16)
                check($sformatf("to_wait%0d", i), ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd4));
            else
                check("to_err", ex(0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 2'd0, 8'd4));
        end
        step();
        check("to_status", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd3, 8'd4));

        // Back-to-back: req and beat_ok held, period of 3 (ack, rdy, status)
        drive(1, 8'd1, 0, 0, 1);
        for (int k = 0; k < 9; k++) begin
            step();
            case (k % 3)
                0: check($sformatf("b2b%0d", k), ex(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd1));
                1: check($sformatf("b2b%0d", k), ex(0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 2'd0, 8'd0));
                default: check($sformatf("b2b%0d", k), ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'd1, 8'd0));
            endcase
        end

        // Reset in the middle of a transfer
        drive(1, 8'd5, 1, 0, 0);
        step();
        check("mid_start", ex(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'd0, 8'd5));
        drive(0, 8'd0, 0, 0, 1);
        step();
        check("mid_beat", ex(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd4));
        drive(0, 8'd0, 0, 0, 0);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_async", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        step();
        check("mid_rst_held", ex(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 8'd0));
        rst = 1'b1;
        init_seq("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
